// File: rtl/fma_sign_resolve_if.sv
// Handshake bundle for the FMA sign resolve stage: upstream entry
// fields with valid/ready, downstream result fields with valid/ready.
interface fma_sign_resolve_if;
    logic       in_valid;
    logic       in_ready;
    logic       s_tmp;
    logic       final_m;
    logic       sum_neg;
    logic       sum_zero;
    logic [1:0] rnd_mode;
    logic [3:0] tag_in;
    logic       out_valid;
    logic       out_ready;
    logic       s_final;
    logic       z_final;
    logic [3:0] tag_out;

    modport master (
        output in_valid,
        output s_tmp,
        output final_m,
        output sum_neg,
        output sum_zero,
        output rnd_mode,
        output tag_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  s_final,
        input  z_final,
        input  tag_out
    );

    modport slave (
        input  in_valid,
        input  s_tmp,
        input  final_m,
        input  sum_neg,
        input  sum_zero,
        input  rnd_mode,
        input  tag_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output s_final,
        output z_final,
        output tag_out
    );
endinterface

// File: rtl/fma_sign_resolve.sv
// Two-stage FMA result sign/zero resolver with cancellation counter.
// Define VFPU_SIGN_RDN_EN to give exact-cancellation zeros a -0 under RDN.
module fma_sign_resolve (
    input  logic                clk,
    input  logic                rst_n,
    fma_sign_resolve_if.slave   bus,
    input  logic                flush,
    input  logic                cnt_clr,
    output logic [15:0]         cancel_cnt
);

    typedef struct packed {
        logic       s_tmp;
        logic       final_m;
        logic       sum_neg;
        logic       sum_zero;
        logic [1:0] rnd_mode;
        logic [3:0] tag;
    } s1_t;

    typedef struct packed {
        logic       sign;
        logic       zero;
        logic [3:0] tag;
    } s2_t;

    s1_t  s1_q;
    s2_t  s2_q;
    logic v1;
    logic v2;
    logic adv1;
    logic acc;
    logic load2;
    logic cancel1;
    logic zero_sign;
    logic sign_res;

    assign adv1         = v1 & (~v2 | bus.out_ready);
    assign bus.in_ready = ~flush & (~v1 | adv1);
    assign acc          = bus.in_valid & bus.in_ready;
    assign load2        = adv1 & ~flush;
    assign cancel1      = ~s1_q.final_m & s1_q.sum_zero;

`ifdef VFPU_SIGN_RDN_EN
    assign zero_sign = (s1_q.rnd_mode == 2'b10);
`else
    logic unused_rnd;
    assign zero_sign  = 1'b0;
    assign unused_rnd = ^s1_q.rnd_mode;
`endif

    // Effective addition keeps the handler sign; subtraction flips on a
    // negative magnitude result; exact cancellation takes the zero sign.
    always_comb begin
        sign_res = 1'b0;
        unique case (1'b1)
            s1_q.final_m:
                sign_res = s1_q.s_tmp;
            ~s1_q.final_m & s1_q.sum_zero:
                sign_res = zero_sign;
            ~s1_q.final_m & ~s1_q.sum_zero:
                sign_res = s1_q.s_tmp ^ s1_q.sum_neg;
            default:
                sign_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else if (acc) begin
            v1 <= 1'b1;
        end else if (adv1) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (acc) begin
            s1_q.s_tmp    <= bus.s_tmp;
            s1_q.final_m  <= bus.final_m;
            s1_q.sum_neg  <= bus.sum_neg;
            s1_q.sum_zero <= bus.sum_zero;
            s1_q.rnd_mode <= bus.rnd_mode;
            s1_q.tag      <= bus.tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (flush) begin
            v2 <= 1'b0;
        end else if (adv1) begin
            v2 <= 1'b1;
        end else if (bus.out_ready) begin
            v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (load2) begin
            s2_q.sign <= sign_res;
            s2_q.zero <= s1_q.sum_zero;
            s2_q.tag  <= s1_q.tag;
        end
    end

    // Counts only entries that actually reach S2, so flushed ones are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel_cnt <= 16'h0000;
        end else if (cnt_clr) begin
            cancel_cnt <= 16'h0000;
        end else if (load2 && cancel1 && cancel_cnt != 16'hFFFF) begin
            cancel_cnt <= cancel_cnt + 16'h0001;
        end
    end

    assign bus.out_valid = v2;
    assign bus.s_final   = s2_q.sign;
    assign bus.z_final   = s2_q.zero;
    assign bus.tag_out   = s2_q.tag;

endmodule

// File: tb/tb_fma_sign_resolve.sv
// Randomized and directed bench for fma_sign_resolve against a
// queue-based reference model of the two-stage pipeline.
module tb_fma_sign_resolve;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        cnt_clr;
    logic [15:0] cancel_cnt;

    fma_sign_resolve_if bus();

    fma_sign_resolve dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .cancel_cnt (cancel_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       z;
        logic [3:0] tag;
        logic       canc;
        bit         staged;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_cnt;
    int          n_cmp;
    int          n_bad;

`ifdef VFPU_SIGN_RDN_EN
    localparam bit RDN_EN = 1'b1;
`else
    localparam bit RDN_EN = 1'b0;
`endif

    function automatic logic ref_sign(logic fm, logic st, logic sn,
                                      logic sz, logic [1:0] rm);
        if (fm) return st;
        if (!sz) return st ^ sn;
        return RDN_EN && (rm == 2'b10);
    endfunction

    function automatic logic m_in_ready();
        return !flush && !(q.size() == 2 && !bus.out_ready);
    endfunction

    function automatic logic m_out_valid();
        return q.size() > 0 && q[0].staged;
    endfunction

    task automatic model_edge();
        ent_t e;
        logic acc;
        logic inc;
        acc = bus.in_valid && m_in_ready();
        inc = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (m_out_valid() && bus.out_ready) void'(q.pop_front());
            if (q.size() > 0 && !q[0].staged) begin
                q[0].staged = 1'b1;
                inc = q[0].canc;
            end
            if (acc) begin
                e.s = ref_sign(bus.final_m, bus.s_tmp, bus.sum_neg,
                               bus.sum_zero, bus.rnd_mode);
                e.z = bus.sum_zero;
                e.tag = bus.tag_in;
                e.canc = !bus.final_m && bus.sum_zero;
                e.staged = 1'b0;
                q.push_back(e);
            end
        end
        if (cnt_clr) m_cnt = 16'h0000;
        else if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_cnt = 16'h0000;
        end else begin
            model_edge();
        end
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic fm, logic st, logic sn,
                         logic sz, logic [1:0] rm, logic [3:0] tg);
        bus.in_valid = v;
        bus.final_m  = fm;
        bus.s_tmp    = st;
        bus.sum_neg  = sn;
        bus.sum_zero = sz;
        bus.rnd_mode = rm;
        bus.tag_in   = tg;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        cnt_clr = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'hF);
        q.delete();
        m_cnt = 16'h0000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if ({bus.s_final, bus.z_final, bus.tag_out} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_data: got %b%b%h want 000",
                     bus.s_final, bus.z_final, bus.tag_out);
        end
        n_cmp++;
        if (cancel_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_cnt: got %h want 0000", cancel_cnt);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    endtask

    task automatic test_sign_stream();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        n_cmp++;
        if ({bus.out_valid, bus.s_final, bus.tag_out} !== {2'b11, 4'h1}) begin
            n_bad++;
            $display("FAIL stream_first: got v%b s%b t%h want v1 s1 t1",
                     bus.out_valid, bus.s_final, bus.tag_out);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.s_final, bus.tag_out} !== {2'b11, 4'h2}) begin
            n_bad++;
            $display("FAIL stream_second: got v%b s%b t%h want v1 s1 t2",
                     bus.out_valid, bus.s_final, bus.tag_out);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_drain: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_cancel();
        logic [15:0] c0;
        logic        want_s;
        c0 = m_cnt;
        want_s = RDN_EN;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'h3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.s_final, bus.z_final, bus.tag_out}
            !== {1'b1, want_s, 1'b1, 4'h3}) begin
            n_bad++;
            $display("FAIL cancel_out: got v%b s%b z%b t%h want v1 s%b z1 t3",
                     bus.out_valid, bus.s_final, bus.z_final,
                     bus.tag_out, want_s);
        end
        n_cmp++;
        if (cancel_cnt !== c0 + 16'h0001) begin
            n_bad++;
            $display("FAIL cancel_cnt: got %h want %h", cancel_cnt, c0 + 16'h1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h4);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h6);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.s_final, bus.tag_out}
                !== {3'b010, 4'h4}) begin
                n_bad++;
                $display("FAIL stall_%0d: got r%b v%b s%b t%h want r0 v1 s0 t4",
                         i, bus.in_ready, bus.out_valid, bus.s_final,
                         bus.tag_out);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        n_cmp++;
        if ({bus.out_valid, bus.s_final, bus.tag_out} !== {2'b11, 4'h5}) begin
            n_bad++;
            $display("FAIL order_5: got v%b s%b t%h want v1 s1 t5",
                     bus.out_valid, bus.s_final, bus.tag_out);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.tag_out} !== {1'b1, 4'h6}) begin
            n_bad++;
            $display("FAIL order_6: got v%b t%h want v1 t6",
                     bus.out_valid, bus.tag_out);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL order_drain: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h7);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h8);
        tick();
        bus.out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h9);
        c0 = m_cnt;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got %b want 0", bus.in_ready);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (cancel_cnt !== c0) begin
            n_bad++;
            $display("FAIL flush_cnt: got %h want %h", cancel_cnt, c0);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_no_accept: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 2) == 0,
                  2'($urandom), 4'($urandom));
            bus.out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 99) < 3;
            cnt_clr = $urandom_range(0, 99) < 2;
            #1;
            n_cmp++;
            if (bus.in_ready !== m_in_ready() ||
                bus.out_valid !== m_out_valid()) begin
                n_bad++;
                $display("FAIL rnd_hs_%0d: got r%b v%b want r%b v%b", i,
                         bus.in_ready, bus.out_valid,
                         m_in_ready(), m_out_valid());
            end
            if (m_out_valid()) begin
                n_cmp++;
                if ({bus.s_final, bus.z_final, bus.tag_out}
                    !== {q[0].s, q[0].z, q[0].tag}) begin
                    n_bad++;
                    $display("FAIL rnd_data_%0d: got s%b z%b t%h want s%b z%b t%h",
                             i, bus.s_final, bus.z_final, bus.tag_out,
                             q[0].s, q[0].z, q[0].tag);
                end
            end
            n_cmp++;
            if (cancel_cnt !== m_cnt) begin
                n_bad++;
                $display("FAIL rnd_cnt_%0d: got %h want %h", i, cancel_cnt, m_cnt);
            end
            tick();
        end
        flush = 1'b0;
        cnt_clr = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        repeat (3) tick();
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'hC);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
        n_cmp++;
        if (cancel_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_reach: got %h want ffff", cancel_cnt);
        end
        repeat (3) tick();
        n_cmp++;
        if (cancel_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got %h want ffff", cancel_cnt);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (cancel_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL sat_clr: got %h want 0000", cancel_cnt);
        end
        tick();
        n_cmp++;
        if (cancel_cnt !== 16'h0001) begin
            n_bad++;
            $display("FAIL sat_after_clr: got %h want 0001", cancel_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 4'hD);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || cancel_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_rst: got v%b c%h want v0 c0000",
                     bus.out_valid, cancel_cnt);
        end
        q.delete();
        m_cnt = 16'h0000;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hA);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_early: got %b want 0", bus.out_valid);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.s_final, bus.z_final, bus.tag_out}
            !== {3'b110, 4'hA}) begin
            n_bad++;
            $display("FAIL post_rst_out: got v%b s%b z%b t%h want v1 s1 z0 ta",
                     bus.out_valid, bus.s_final, bus.z_final, bus.tag_out);
        end
        n_cmp++;
        if (cancel_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_rst_cnt: got %h want 0000", cancel_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        @(negedge clk);
        test_sign_stream();
        test_cancel();
        test_backpressure();
        test_flush();
        test_random();
        test_saturate();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
